// File: rtl/abz_enc_gen.sv
// abz_enc_gen: quadrature encoder emulator stepping a position toward a target
module abz_enc_gen #(
    parameter int BIT_LENGTH = 12,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  INIT_EN,
    input  logic [BIT_LENGTH-1:0] INIT_POS,
    input  logic                  TARGET_VLD,
    input  logic [BIT_LENGTH-1:0] TARGET_POS,
    input  logic [DIV_WIDTH-1:0]  EDGE_DIV,
    output logic [BIT_LENGTH-1:0] POS_OUT,
    output logic                  A_OUT,
    output logic                  B_OUT,
    output logic                  Z_OUT,
    output logic                  BUSY,
    output logic                  DONE
);
    typedef enum logic {IDLE, MOVE} state_t;
    state_t state_q, state_d;
    logic [BIT_LENGTH-1:0] pos_q, pos_d, tgt_q, tgt_d, diff;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, reload;
    logic done_q, done_d, a_q, b_q, z_q;
    assign reload = (EDGE_DIV == '0) ? '0 : EDGE_DIV - 1'b1;
    assign diff = tgt_q - pos_q;
    // next state: init beats retarget beats stepping; direction is the shortest path, ties go down
    always_comb begin
        state_d = state_q;
        pos_d = pos_q;
        tgt_d = tgt_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        if (INIT_EN) begin
            pos_d = INIT_POS;
            state_d = IDLE;
            cnt_d = '0;
        end else if (TARGET_VLD) begin
            tgt_d = TARGET_POS;
            if (TARGET_POS == pos_q) begin
                state_d = IDLE;
                done_d = 1'b1;
            end else if (state_q == IDLE) begin
                state_d = MOVE;
                cnt_d = reload;
            end
        end else if (state_q == MOVE && EN) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                pos_d = diff[BIT_LENGTH-1] ? pos_q - 1'b1 : (diff != '0) ? pos_q + 1'b1 : pos_q;
                cnt_d = reload;
                if (pos_d == tgt_q) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end
            end
        end
    end
    // state registers; A/B/Z are registered from the next position so they move with POS_OUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pos_q <= '0;
            tgt_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            a_q <= 1'b0;
            b_q <= 1'b0;
            z_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q <= pos_d;
            tgt_q <= tgt_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            a_q <= pos_d[1] ^ pos_d[0];
            b_q <= pos_d[1];
            z_q <= (pos_d == '0);
        end
    end
    assign POS_OUT = pos_q;
    assign A_OUT = a_q;
    assign B_OUT = b_q;
    assign Z_OUT = z_q;
    assign BUSY = (state_q == MOVE);
    assign DONE = done_q;
endmodule

// File: doc/abz_enc_gen.md
Name: abz_enc_gen

Overview:
- Quadrature (ABZ) encoder emulator: the transmit side of the ABZ quadrature decoder.
- Holds an internal position and steps it one count at a time toward a commanded target, at a programmable edge rate.
- Drives A/B/Z waveforms that the decoder counts back to the same value.
- Used as a motor/encoder stand-in for loopback test and for HIL stimulus.

Parameters:
- BIT_LENGTH, 12, width of position/target; position wraps modulo 2^BIT_LENGTH.
- DIV_WIDTH, 16, width of the edge-interval divisor.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  run enable; low pauses motion (interval counter frozen, position held).
- INIT_EN  input  1  level; while high, POS_OUT <= INIT_POS, state IDLE, interval counter cleared.
- INIT_POS  input  BIT_LENGTH  preload position.
- TARGET_VLD  input  1  one-cycle strobe accepting TARGET_POS.
- TARGET_POS  input  BIT_LENGTH  commanded position.
- EDGE_DIV  input  DIV_WIDTH  clocks between successive quadrature edges; 0 treated as 1.
- POS_OUT  output  BIT_LENGTH  current emulated position.
- A_OUT  output  1  quadrature A.
- B_OUT  output  1  quadrature B.
- Z_OUT  output  1  index; high while POS_OUT == 0.
- BUSY  output  1  high in MOVE state.
- DONE  output  1  one-cycle pulse when target is reached or a target equal to the current position is accepted.

Behaviour:
- Reset (RST high at CLK edge): POS_OUT=0, A_OUT=0, B_OUT=0, Z_OUT=1, BUSY=0, DONE=0, state IDLE, interval counter 0, stored target 0.
- Encoding from POS_OUT[1:0]: 00->A0B0, 01->A1B0, 10->A1B1, 11->A0B1.
  - Count up = A rises while B low; matches the decoder's up direction.
  - A_OUT, B_OUT and Z_OUT are flops loaded from the next position value, so they change in the same cycle as POS_OUT.
  - A_OUT, B_OUT and Z_OUT are glitch-free; no combinational decode on outputs.
- Direction: D = (target - POS_OUT) mod 2^BIT_LENGTH.
  - D MSB=0 and D!=0: step up. D MSB=1: step down.
  - Result is the shortest path across wrap; a tie (D = 2^(BIT_LENGTH-1)) steps down.
  - Direction is recomputed every step.
- FSM states IDLE and MOVE.
  - IDLE, TARGET_VLD, TARGET_POS != POS_OUT: store target; interval counter <= max(EDGE_DIV,1)-1; go to MOVE; BUSY=1 the next cycle.
  - IDLE, TARGET_VLD, TARGET_POS == POS_OUT: DONE pulses the next cycle; stay IDLE.
  - MOVE, EN=1, counter != 0: counter decrements.
  - MOVE, EN=1, counter == 0: step POS_OUT +/-1 (wraps all-ones<->0); reload counter with max(EDGE_DIV,1)-1.
    - If the new POS_OUT == target: go to IDLE; DONE pulses in the same cycle BUSY falls.
  - MOVE, EN=0: no counter change, no step; BUSY stays 1.
- Timing (EN continuously high):
  - First step lands max(EDGE_DIV,1) cycles after the TARGET_VLD cycle.
  - Subsequent steps are exactly max(EDGE_DIV,1) cycles apart.
  - EDGE_DIV is sampled at each reload, so changes take effect on the next interval.
- Retarget in MOVE (TARGET_VLD): the target is replaced and the counter is not reloaded.
  - If the new target == POS_OUT: go to IDLE, DONE pulses the next cycle, no further step.
- Priority, high to low: RST > INIT_EN > TARGET_VLD > step.
  - INIT_EN aborts motion with no DONE and ignores a simultaneous TARGET_VLD.
  - A/B/Z jump to the encoding of INIT_POS; the jump may be a non-quadrature transition, which is the user's responsibility.
- At most one count change per cycle; A and B never toggle in the same cycle except via INIT_EN.
- Reset mid-move returns all state to reset values on the next edge.

Test Plan:
- Reset, EDGE_DIV=3, TARGET_POS=5 strobe at cycle 0 -> POS_OUT steps 1..5 at cycles 3,6,9,12,15; A/B sequence A1B0,A1B1,A0B1,A0B0,A1B0; DONE pulses at cycle 15; BUSY high cycles 1-15.
- INIT_POS=2 (INIT_EN 1 cycle), EDGE_DIV=1, target 4094 (BIT_LENGTH=12) -> steps down 1,0,4095,4094 on consecutive cycles; Z_OUT high only while POS_OUT=0; DONE at POS=4094.
- Target 10 from 0, EDGE_DIV=2; EN low for 5 cycles after the 3rd step -> no steps during the pause; the 4th step comes exactly 2 enabled cycles after the 3rd; final DONE at POS=10.
- While moving 0->20, retarget to 2 when POS_OUT=6 -> direction reverses; POS_OUT steps 5,4,3,2; DONE once.
- Mid-move INIT_EN with INIT_POS=100 and TARGET_VLD in the same cycle -> POS_OUT=100, BUSY=0, no DONE, target ignored.
- EDGE_DIV=0, target 3 from 0 -> steps on 3 consecutive cycles (treated as 1); TARGET_POS equal to POS_OUT while IDLE -> DONE next cycle with BUSY staying 0.
